// File: rtl/params_pkg.sv
// Shared constants for the pipeline stage buffers.
package params_pkg;

  localparam int BUF_MAX_DEPTH = 16;
  localparam int BUF_MAX_WIDTH = 1024;

  // Pointer width for a buffer of the given depth; a one-entry buffer still
  // gets a one-bit pointer so the index vectors never collapse to zero width.
  function automatic int buf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: in-order FIFO between two pipeline stages with a flush port
// and a registered output side. Defining PIPE_STAGE_BUF_BYPASS_EN compiles in
// a zero-latency path that hands the input straight to the consumer while the
// buffer is empty.
module pipe_stage_buf
  import params_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(0)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = buf_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > BUF_MAX_DEPTH) begin : g_depth_chk
    $error("pipe_stage_buf: DEPTH out of range");
  end
  if (WIDTH < 1 || WIDTH > BUF_MAX_WIDTH) begin : g_width_chk
    $error("pipe_stage_buf: WIDTH out of range");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             bypass_take;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign in_ready_o = !full;
  assign count_o    = count;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
  // An item offered to an empty buffer and taken the same cycle is never stored.
  assign bypass_take = empty && !flush_i && in_valid_i && out_ready_i;
  assign out_valid_o = !flush_i && (!empty || in_valid_i);
  assign out_data_o  = flush_i     ? BUBBLE      :
                       !empty      ? mem[rd_ptr] :
                       in_valid_i  ? in_data_i   : BUBBLE;
`else
  assign bypass_take = 1'b0;
  assign out_valid_o = !flush_i && !empty;
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : BUBBLE;
`endif

  // Pushes are judged against the occupancy before any same-cycle pop, so a
  // full buffer refuses input even while it is draining.
  assign push = in_valid_i && in_ready_o && !flush_i && !bypass_take;
  assign pop  = !flush_i && !empty && out_ready_i;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  // Pointer and occupancy update; reset outranks flush, which outranks traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int          W   = 32;
  localparam int          D   = 3;
  localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    count;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic [31:0] got[$];
  logic        obs_valid;
  logic [31:0] obs_data;
  logic [31:0] obs_count;
  logic        obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the queue model, then let the
  // edge happen and advance the model by the FIFO rules.
  task automatic tick(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic rs);
    logic        ev;
    logic [31:0] ed;
    int          sz;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; flush = f; rst = rs;
    #1;
    sz = mq.size();
    if (f)                 begin ev = 1'b0; ed = BUB;   end
    else if (sz > 0)       begin ev = 1'b1; ed = mq[0]; end
    else if (BYP && v)     begin ev = 1'b1; ed = d;     end
    else                   begin ev = 1'b0; ed = BUB;   end
    obs_valid = out_valid; obs_data = out_data;
    obs_count = 32'(count); obs_ready = in_ready;
    chk("m_valid", 32'(obs_valid), 32'(ev));
    chk("m_data",  obs_data, ed);
    chk("m_count", obs_count, 32'(sz));
    chk("m_ready", 32'(obs_ready), 32'(sz != D));
    if (ev && r) got.push_back(ed);
    @(posedge clk);
    if (rs || f) begin
      mq.delete();
    end else begin
      if (ev && r && sz > 0) void'(mq.pop_front());
      if (v && sz != D && !(ev && r && sz == 0)) mq.push_back(d);
    end
  endtask

  task automatic idle(input logic r);
    tick(1'b0, 32'h0, r, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // reset state
    idle(1'b0);
    chk("rst_count", obs_count, 32'd0);
    chk("rst_ready", 32'(obs_ready), 32'd1);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_data",  obs_data, BUB);

    // fill
    tick(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("fill_count", obs_count, 32'd3);
    chk("fill_ready", 32'(obs_ready), 32'd0);
    chk("fill_data",  obs_data, 32'hA1);

    // full with simultaneous push and pop: push refused
    tick(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
    chk("full_pop_data", obs_data, 32'hA1);
    idle(1'b0);
    chk("full_count", obs_count, 32'd2);
    chk("full_next",  obs_data, 32'hA2);

    // flush with an incoming item
    tick(1'b1, 32'hBB, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 32'(obs_valid), 32'd0);
    chk("flush_data",  obs_data, BUB);
    idle(1'b1);
    chk("flush_count", obs_count, 32'd0);
    chk("flush_drop",  32'(obs_valid), 32'd0);

    // wrap: stream 1..10 with both sides ready
    got.delete();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      if (i >= 2) chk("wrap_count", obs_count, BYP ? 32'd0 : 32'd1);
    end
    idle(1'b1);
    chk("wrap_len", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++) chk("wrap_order", got[i], 32'(i + 1));

    // reset mid-stream
    tick(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("mid_pre_count", obs_count, 32'd2);
    idle(1'b0);
    chk("mid_count", obs_count, 32'd0);
    chk("mid_valid", 32'(obs_valid), 32'd0);
    chk("mid_ready", 32'(obs_ready), 32'd1);

    // bypass vs registered latency
    tick(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    if (BYP) begin
      chk("byp_valid", 32'(obs_valid), 32'd1);
      chk("byp_data",  obs_data, 32'h55);
      idle(1'b0);
      chk("byp_count", obs_count, 32'd0);
    end else begin
      chk("lat_valid0", 32'(obs_valid), 32'd0);
      idle(1'b1);
      chk("lat_valid1", 32'(obs_valid), 32'd1);
      chk("lat_data1",  obs_data, 32'h55);
    end

    // randomized traffic against the queue model
    for (int n = 0; n < 500; n++) begin
      tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 40) == 0));
    end
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..1024).
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries (1..16, non-power-of-two allowed).
REQ-003 SHALL have parameter BUBBLE, default WIDTH'(0), value driven on out_data_o whenever out_valid_o=0.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port flush_i, input, 1, discards all held and incoming entries.
REQ-008 SHALL have port in_valid_i, input, 1, producer has data.
REQ-009 SHALL have port in_ready_o, output, 1, buffer can accept.
REQ-010 SHALL have port in_data_i, input, WIDTH, producer payload.
REQ-011 SHALL have port out_valid_o, output, 1, consumer data valid.
REQ-012 SHALL have port out_ready_i, input, 1, consumer accepts.
REQ-013 SHALL have port out_data_o, output, WIDTH, consumer payload.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-015 SHALL be an in-order FIFO: push when in_valid_i & in_ready_o, pop when out_valid_o & out_ready_i.
REQ-016 SHALL drive in_ready_o = (count_o != DEPTH), with no combinational dependence on out_ready_i.
REQ-017 SHALL, when count_o > 0, drive out_valid_o=1 and out_data_o = oldest entry, both registered.
REQ-018 SHALL support simultaneous push and pop at any non-full occupancy, count unchanged, order preserved.
REQ-019 SHALL refuse push at count_o==DEPTH even if a pop occurs that cycle.
REQ-020 SHALL wrap read/write pointers from DEPTH-1 to 0 explicitly (valid for non-power-of-two DEPTH).
REQ-021 SHALL, on flush_i=1, force out_valid_o=0 and out_data_o=BUBBLE that cycle, record no pop, drop any push, and set count_o=0 next cycle.
REQ-022 SHALL hold out_data_o stable while out_valid_o=1 and out_ready_i=0.
REQ-023 SHALL, without bypass (see REQ-027), give a minimum latency of 1 cycle from push to out_valid_o.

Reset
REQ-024 SHALL, while rst_i=1 at a clock edge, clear count and both pointers, giving count_o=0, out_valid_o=0, out_data_o=BUBBLE, in_ready_o=1 the following cycle.
REQ-025 SHALL give rst_i priority over flush_i, push and pop; a reset mid-stream discards all entries.
REQ-026 SHALL NOT require storage array contents to be reset.

Configuration
REQ-027 SHALL compile in zero-latency bypass when PIPE_STAGE_BUF_BYPASS_EN is defined: when count_o==0 and flush_i=0, out_valid_o=in_valid_i and out_data_o=in_data_i combinationally; if out_ready_i=1 that cycle the item is consumed and not stored.
REQ-028 SHALL, without PIPE_STAGE_BUF_BYPASS_EN, keep out_valid_o and out_data_o purely register-driven (REQ-023).

Structure
REQ-029 SHALL add no new typedefs to params_pkg; pipeline instances use WIDTH=$bits(id_ex_t)/$bits(ex_mem_t)/$bits(mem_wb_t) and BUBBLE from reset_id_ex()/reset_ex_mem()/reset_mem_wb().
REQ-030 SHALL place any buffer-specific shared constants (e.g. max DEPTH = 16) in params_pkg.
REQ-031 SHALL be a single module with no sub-modules; storage, pointers and count are inline.

Verification
REQ-032 SHALL cover fill: WIDTH=32, DEPTH=3, push 0xA1,0xA2,0xA3 with out_ready_i=0 -> count_o=3, in_ready_o=0, out_data_o=0xA1.
REQ-033 SHALL cover full plus simultaneous push and pop: DEPTH=3 full, in_valid_i=1, out_ready_i=1 -> pop 0xA1, push refused, count_o=2.
REQ-034 SHALL cover wrap: DEPTH=3, stream 0x01..0x0A with both sides always ready -> output sequence 0x01..0x0A in order, count_o constant at 1 (0 with bypass).
REQ-035 SHALL cover flush: count_o=2, flush_i=1 with in_valid_i=1 -> out_valid_o=0 and out_data_o=BUBBLE (0x00000013) that cycle, count_o=0 next cycle, pushed item never emerges.
REQ-036 SHALL cover reset mid-stream: count_o=2, rst_i=1 for one cycle -> count_o=0, out_valid_o=0, in_ready_o=1 next cycle.
REQ-037 SHALL cover bypass: with PIPE_STAGE_BUF_BYPASS_EN, empty buffer, push 0x55 with out_ready_i=1 -> out_data_o=0x55 same cycle, count_o stays 0; without the macro -> out_valid_o=1 one cycle later.
